ysyx22041405_lsu_ctrl: RTL and testbench

Load/store stage controller sitting between the execute stage and the writeback unit. It accepts one instruction at a time from EX, issues any data-memory access on a simple request/response bus, and aligns and extends load data. It then delivers a fully formed writeback packet to the WBU with valid/ready. It is the transmitting end of the LS→WB interface: the WBU only unpacks and commits what this block sends.

---
 rtl/ysyx22041405_lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ysyx22041405_lsu_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_lsu_ctrl.sv
// Load/store stage: one instruction at a time from EX, optional bus access, packet to WBU.
// Define YSYX22041405_LSU_MISALIGN_CHK_EN to trap misaligned half/word accesses.
module ysyx22041405_lsu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic [WIDTH-1:0] in_alu_res,
    input  logic [WIDTH-1:0] in_st_data,
    input  logic [4:0]       in_rf_waddr,
    input  logic             in_rf_we,
    input  logic             in_mem_ren,
    input  logic             in_mem_wen,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic             in_ebreak,
    input  logic             in_inst_valid,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    output logic             mem_req_wen,
    output logic [WIDTH-1:0] mem_req_wdata,
    output logic [3:0]       mem_req_wstrb,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [4:0]       out_rf_waddr,
    output logic [WIDTH-1:0] out_rf_wdata,
    output logic [WIDTH-1:0] out_dm_rdata,
    output logic             out_rf_we,
    output logic             out_ebreak,
    output logic             out_inst_valid
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t           state;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             ren_q;
    logic             is_mem;
    logic             misalign;
    logic [3:0]       wstrb_d;
    logic [WIDTH-1:0] wdata_d;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [WIDTH-1:0] ld_ext;

    assign is_mem = in_mem_ren | in_mem_wen;

`ifdef YSYX22041405_LSU_MISALIGN_CHK_EN
    assign misalign = (in_size == 2'd1 && in_alu_res[0])
                    || (in_size[1] && in_alu_res[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        wstrb_d = 4'b1111;
        wdata_d = in_st_data;
        unique case (in_size)
            2'd0: begin
                wstrb_d = 4'b0001 << in_alu_res[1:0];
                wdata_d = {4{in_st_data[7:0]}};
            end
            2'd1: begin
                wstrb_d = 4'b0011 << {in_alu_res[1], 1'b0};
                wdata_d = {2{in_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the truncated address captured at accept time.
    assign ld_b = mem_rsp_rdata[{off_q, 3'b000} +: 8];
    assign ld_h = mem_rsp_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = mem_rsp_rdata;
        unique case (size_q)
            2'd0: ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
            2'd1: ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            off_q          <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            ren_q          <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wen    <= 1'b0;
            mem_req_wdata  <= '0;
            mem_req_wstrb  <= '0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_inst       <= '0;
            out_rf_waddr   <= '0;
            out_rf_wdata   <= '0;
            out_dm_rdata   <= '0;
            out_rf_we      <= 1'b0;
            out_ebreak     <= 1'b0;
            out_inst_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    in_ready       <= 1'b0;
                    off_q          <= in_alu_res[1:0];
                    size_q         <= in_size;
                    uns_q          <= in_unsigned;
                    ren_q          <= in_mem_ren;
                    mem_req_addr   <= {in_alu_res[WIDTH-1:2], 2'b00};
                    mem_req_wen    <= in_mem_wen;
                    mem_req_wdata  <= wdata_d;
                    mem_req_wstrb  <= in_mem_wen ? wstrb_d : 4'b0000;
                    out_pc         <= in_pc;
                    out_inst       <= in_inst;
                    out_rf_waddr   <= in_rf_waddr;
                    out_rf_wdata   <= in_alu_res;
                    out_dm_rdata   <= '0;
                    out_ebreak     <= in_ebreak;
                    if (is_mem && misalign) begin
                        out_rf_we      <= 1'b0;
                        out_inst_valid <= 1'b0;
                        out_valid      <= 1'b1;
                        state          <= OUT;
                    end else begin
                        out_rf_we      <= in_rf_we & ~in_mem_wen;
                        out_inst_valid <= in_inst_valid;
                        mem_req_valid  <= is_mem;
                        out_valid      <= ~is_mem;
                        state          <= is_mem ? REQ : OUT;
                    end
                end
                REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (mem_rsp_valid) begin
                    if (ren_q) begin
                        out_rf_wdata <= ld_ext;
                        out_dm_rdata <= mem_rsp_rdata;
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx22041405_lsu_ctrl.sv
// Randomized bench for ysyx22041405_lsu_ctrl with a transaction-level reference model.
// Honors YSYX22041405_LSU_MISALIGN_CHK_EN in the model as well.
module tb_ysyx22041405_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst, in_alu_res, in_st_data;
    logic [4:0]  in_rf_waddr;
    logic        in_rf_we, in_mem_ren, in_mem_wen;
    logic [1:0]  in_size;
    logic        in_unsigned, in_ebreak, in_inst_valid;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst, out_rf_wdata, out_dm_rdata;
    logic [4:0]  out_rf_waddr;
    logic        out_rf_we, out_ebreak, out_inst_valid;

    always #5 clk = ~clk;

    ysyx22041405_lsu_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .in_alu_res(in_alu_res), .in_st_data(in_st_data),
        .in_rf_waddr(in_rf_waddr), .in_rf_we(in_rf_we),
        .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_ebreak(in_ebreak), .in_inst_valid(in_inst_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .out_dm_rdata(out_dm_rdata), .out_rf_we(out_rf_we),
        .out_ebreak(out_ebreak), .out_inst_valid(out_inst_valid)
    );

    typedef struct {
        logic [31:0] pc, inst, alu, st, rdata;
        logic [4:0]  waddr;
        logic        we, ren, wen, uns, eb, iv;
        logic [1:0]  size;
    } txn_t;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model outputs for the transaction in flight
    bit          exp_mem;
    logic [31:0] exp_addr, exp_wdata, exp_pc, exp_inst, exp_rf_wdata, exp_dm;
    logic [3:0]  exp_wstrb;
    logic [4:0]  exp_waddr;
    logic        exp_wen, exp_we, exp_eb, exp_iv;

    // DUT values captured for literal checks
    logic [31:0] last_req_addr, last_req_wdata, last_rf_wdata, last_dm;
    logic [3:0]  last_req_wstrb;
    logic [4:0]  last_waddr;
    logic        last_we, last_iv;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model(input txn_t t);
        int off, hoff;
        bit mis;
        logic [31:0] b;
        off = int'(t.alu % 4);
        mis = 1'b0;
`ifdef YSYX22041405_LSU_MISALIGN_CHK_EN
        if (t.size == 2'd1 && off % 2 == 1) mis = 1'b1;
        if (t.size == 2'd2 && off != 0) mis = 1'b1;
`endif
        exp_mem = (t.ren || t.wen) && !mis;
        exp_addr = t.alu - 32'(off);
        exp_wen = t.wen;
        if (t.size == 2'd0) begin
            exp_wstrb = 4'(1 << off);
            exp_wdata = (t.st & 32'hFF) * 32'h01010101;
            b = (t.rdata >> (8 * off)) & 32'hFF;
            if (!t.uns && b >= 128) b = b + 32'hFFFFFF00;
        end else if (t.size == 2'd1) begin
            hoff = (off / 2) * 2;
            exp_wstrb = 4'(3 << hoff);
            exp_wdata = (t.st & 32'hFFFF) * 32'h00010001;
            b = (t.rdata >> (8 * hoff)) & 32'hFFFF;
            if (!t.uns && b >= 32768) b = b + 32'hFFFF0000;
        end else begin
            exp_wstrb = 4'hF;
            exp_wdata = t.st;
            b = t.rdata;
        end
        exp_pc = t.pc;
        exp_inst = t.inst;
        exp_waddr = t.waddr;
        exp_eb = t.eb;
        exp_we = t.we && !t.wen && !mis;
        exp_iv = t.iv && !mis;
        exp_rf_wdata = (t.ren && !mis) ? b : t.alu;
        exp_dm = (t.ren && !mis) ? t.rdata : 32'h0;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int k;
        k = int'($urandom_range(2, 0));
        t.pc = $urandom;
        t.inst = $urandom;
        t.alu = $urandom;
        t.st = $urandom;
        t.rdata = $urandom;
        t.waddr = 5'($urandom);
        t.we = 1'($urandom);
        t.ren = (k == 1);
        t.wen = (k == 2);
        t.size = 2'($urandom_range(2, 0));
        t.uns = 1'($urandom);
        t.eb = 1'($urandom);
        t.iv = 1'($urandom);
        return t;
    endfunction

    task automatic drive(input txn_t t);
        in_pc = t.pc;
        in_inst = t.inst;
        in_alu_res = t.alu;
        in_st_data = t.st;
        in_rf_waddr = t.waddr;
        in_rf_we = t.we;
        in_mem_ren = t.ren;
        in_mem_wen = t.wen;
        in_size = t.size;
        in_unsigned = t.uns;
        in_ebreak = t.eb;
        in_inst_valid = t.iv;
    endtask

    // Compare process: request and packet fields against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (mem_req_valid) begin
                check("req_addr", mem_req_addr, exp_addr);
                check("req_wen", 32'(mem_req_wen), 32'(exp_wen));
                if (exp_wen) begin
                    check("req_wstrb", 32'(mem_req_wstrb), 32'(exp_wstrb));
                    check("req_wdata", mem_req_wdata, exp_wdata);
                end
            end
            if (out_valid) begin
                check("out_pc", out_pc, exp_pc);
                check("out_inst", out_inst, exp_inst);
                check("out_waddr", 32'(out_rf_waddr), 32'(exp_waddr));
                check("out_rf_wdata", out_rf_wdata, exp_rf_wdata);
                check("out_dm_rdata", out_dm_rdata, exp_dm);
                check("out_rf_we", 32'(out_rf_we), 32'(exp_we));
                check("out_ebreak", 32'(out_ebreak), 32'(exp_eb));
                check("out_inst_valid", 32'(out_inst_valid), 32'(exp_iv));
            end
        end
    end

    task automatic run_txn(input txn_t t, input int gd, input int rd,
                           input int od, input bit stall_in);
        model(t);
        last_req_addr = 'x;
        last_req_wdata = 'x;
        last_req_wstrb = 'x;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        drive(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drive(rand_txn());
        @(negedge clk);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        check("req_issue", 32'(mem_req_valid), 32'(exp_mem));
        if (exp_mem) begin
            check("out_early", 32'(out_valid), 32'd0);
            last_req_addr = mem_req_addr;
            last_req_wdata = mem_req_wdata;
            last_req_wstrb = mem_req_wstrb;
            for (int i = 0; i < gd; i++) begin
                mem_rsp_valid = 1'($urandom);
                mem_rsp_rdata = $urandom;
                @(negedge clk);
                check("req_hold", 32'(mem_req_valid), 32'd1);
                check("req_out_low", 32'(out_valid), 32'd0);
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            for (int i = 0; i < rd; i++) begin
                @(negedge clk);
                check("wait_req_low", 32'(mem_req_valid), 32'd0);
                check("wait_out_low", 32'(out_valid), 32'd0);
            end
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = t.rdata;
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            @(negedge clk);
        end
        check("out_valid", 32'(out_valid), 32'd1);
        last_rf_wdata = out_rf_wdata;
        last_dm = out_dm_rdata;
        last_waddr = out_rf_waddr;
        last_we = out_rf_we;
        last_iv = out_inst_valid;
        for (int i = 0; i < od; i++) begin
            in_valid = stall_in;
            if (stall_in) drive(rand_txn());
            mem_rsp_valid = 1'($urandom);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("done_out_low", 32'(out_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, "_req_wen"}, 32'(mem_req_wen), 32'd0);
        check({tag, "_req_wstrb"}, 32'(mem_req_wstrb), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_out_wdata"}, out_rf_wdata, 32'd0);
        check({tag, "_out_we"}, 32'(out_rf_we), 32'd0);
    endtask

    txn_t t;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        out_ready = 1'b0;
        drive(rand_txn());
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // ALU op
        t = rand_txn();
        t.ren = 0; t.wen = 0; t.alu = 32'h1234; t.waddr = 5'd5; t.we = 1;
        model(t);
        check("pin_alu", exp_rf_wdata, 32'h1234);
        run_txn(t, 0, 0, 0, 0);
        check("lit_alu_wdata", last_rf_wdata, 32'h1234);
        check("lit_alu_waddr", 32'(last_waddr), 32'd5);

        // lb / lbu at byte 3
        t = rand_txn();
        t.ren = 1; t.wen = 0; t.size = 0; t.uns = 0;
        t.alu = 32'h80000003; t.rdata = 32'h80FF0000;
        model(t);
        check("pin_lb", exp_rf_wdata, 32'hFFFFFF80);
        run_txn(t, 0, 0, 0, 0);
        check("lit_lb", last_rf_wdata, 32'hFFFFFF80);
        t.uns = 1;
        run_txn(t, 1, 1, 0, 0);
        check("lit_lbu", last_rf_wdata, 32'h00000080);

        // sh upper half
        t = rand_txn();
        t.ren = 0; t.wen = 1; t.size = 1; t.we = 1;
        t.alu = 32'h80000002; t.st = 32'h1234ABCD;
        model(t);
        check("pin_sh_wstrb", 32'(exp_wstrb), 32'hC);
        run_txn(t, 0, 0, 0, 0);
        check("lit_sh_wstrb", 32'(last_req_wstrb), 32'hC);
        check("lit_sh_wdata", last_req_wdata, 32'hABCDABCD);
        check("lit_sh_addr", last_req_addr, 32'h80000000);
        check("lit_sh_we", 32'(last_we), 32'd0);

        // lw with slow grant and response
        t = rand_txn();
        t.ren = 1; t.wen = 0; t.size = 2;
        t.alu = 32'h80000010; t.rdata = 32'hDEADBEEF;
        run_txn(t, 3, 2, 0, 0);
        check("lit_lw_wdata", last_rf_wdata, 32'hDEADBEEF);
        check("lit_lw_dm", last_dm, 32'hDEADBEEF);

        // WBU stall with EX pushing
        t = rand_txn();
        t.ren = 0; t.wen = 0;
        run_txn(t, 0, 0, 4, 1);

        // Reset while waiting for the response, then a late response
        t = rand_txn();
        t.ren = 1; t.wen = 0; t.size = 2; t.alu = 32'h80000020;
        model(t);
        @(negedge clk);
        in_valid = 1'b1;
        drive(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_state("abort");
        end

        // lw at a misaligned address
        t = rand_txn();
        t.ren = 1; t.wen = 0; t.size = 2; t.iv = 1;
        t.alu = 32'h80000002; t.rdata = 32'h01020304;
        run_txn(t, 0, 0, 0, 0);
`ifdef YSYX22041405_LSU_MISALIGN_CHK_EN
        check("lit_mis_iv", 32'(last_iv), 32'd0);
`else
        check("lit_mis_addr", last_req_addr, 32'h80000000);
        check("lit_mis_wdata", last_rf_wdata, 32'h01020304);
`endif

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            run_txn(rand_txn(), int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
